// File: rtl/chip_result_ctrl_if.sv
// Bundle of strobes and status lines between the result controller and the
// per-chip tester blocks; the controller is the master.
interface chip_result_ctrl_if #(
    parameter int NUM_CHIPS = 4
);
    logic [NUM_CHIPS-1:0] Run_vec;
    logic [NUM_CHIPS-1:0] Done_vec;
    logic [NUM_CHIPS-1:0] RSLT_vec;
    logic                 DISP_RSLT;

    modport master (
        output Run_vec,
        output DISP_RSLT,
        input  Done_vec,
        input  RSLT_vec
    );

    modport slave (
        input  Run_vec,
        input  DISP_RSLT,
        output Done_vec,
        output RSLT_vec
    );
endinterface

// File: rtl/chip_result_ctrl.sv
// Launches one chip tester, waits for its settled result (or a timeout),
// acknowledges it and holds pass/fail/timeout plus saturating tallies.
module chip_result_ctrl #(
    parameter int NUM_CHIPS      = 4,
    parameter int SEL_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [SEL_W-1:0]      ChipSel,
    chip_result_ctrl_if.master    tester,
    output logic                  Busy,
    output logic                  Result_valid,
    output logic                  Pass,
    output logic                  Fail,
    output logic                  Timeout,
    output logic [SEL_W-1:0]      Shown_chip,
    output logic [7:0]            Pass_count,
    output logic [7:0]            Fail_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACK,
        S_SHOW
    } state_e;

    localparam int NSEL = 2 ** SEL_W;
    // Selects at or above NUM_CHIPS have no tester behind them.
    localparam logic [NSEL-1:0]      VALID_SEL = NSEL'((64'd1 << NUM_CHIPS) - 64'd1);
    localparam logic [NUM_CHIPS-1:0] RUN_ONE   = NUM_CHIPS'(1);
    localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              start_prev_q;
    logic              done_seen_q, done_seen_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic              valid_q, valid_d;
    logic [SEL_W-1:0]  shown_q, shown_d;
    logic [7:0]        pass_cnt_q, pass_cnt_d;
    logic [7:0]        fail_cnt_q, fail_cnt_d;

    logic                 start_rise;
    logic                 done_sel;
    logic                 rslt_sel;
    logic [NUM_CHIPS-1:0] run_vec;
    logic                 disp_rslt;
    logic                 busy;

    assign start_rise = Start & ~start_prev_q;
    assign done_sel   = tester.Done_vec[shown_q];
    assign rslt_sel   = tester.RSLT_vec[shown_q];

    // NOTE: every signal written here gets its default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        done_seen_d = done_seen_q;
        to_cnt_d    = to_cnt_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        valid_d     = valid_q;
        shown_d     = shown_q;
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        run_vec     = '0;
        disp_rslt   = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            S_IDLE, S_SHOW: begin
                if (start_rise && VALID_SEL[ChipSel]) begin
                    shown_d   = ChipSel;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    valid_d   = 1'b0;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                busy        = 1'b1;
                run_vec     = RUN_ONE << shown_q;
                to_cnt_d    = '0;
                done_seen_d = 1'b0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                busy        = 1'b1;
                done_seen_d = done_sel;
                // Done rises one cycle before RSLT settles; capture on its second high cycle.
                if (done_sel && done_seen_q) begin
                    pass_d  = rslt_sel;
                    fail_d  = ~rslt_sel;
                    state_d = S_ACK;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = S_ACK;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                busy       = 1'b1;
                disp_rslt  = 1'b1;
                pass_cnt_d = (pass_cnt_q != 8'hFF) ? pass_cnt_q + 8'(pass_q) : pass_cnt_q;
                fail_cnt_d = (fail_cnt_q != 8'hFF) ? fail_cnt_q + 8'(fail_q) : fail_cnt_q;
                valid_d    = 1'b1;
                state_d    = S_SHOW;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            done_seen_q  <= 1'b0;
            to_cnt_q     <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            valid_q      <= 1'b0;
            shown_q      <= '0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= Start;
            done_seen_q  <= done_seen_d;
            to_cnt_q     <= to_cnt_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            valid_q      <= valid_d;
            shown_q      <= shown_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end

    assign tester.Run_vec   = run_vec;
    assign tester.DISP_RSLT = disp_rslt;
    assign Busy             = busy;
    assign Result_valid     = valid_q;
    assign Pass             = pass_q;
    assign Fail             = fail_q;
    assign Timeout          = timeout_q;
    assign Shown_chip       = shown_q;
    assign Pass_count       = pass_cnt_q;
    assign Fail_count       = fail_cnt_q;

endmodule

// File: doc/chip_result_ctrl.md
Name: chip_result_ctrl

Overview:
- Sequencer between the user controls/display and the per-chip tester blocks (chip_7410 and siblings).
- Launches the selected tester with a one-cycle Run, waits for its Done, and captures the final RSLT.
- Acknowledges the tester via DISP_RSLT, then holds the pass/fail/timeout result and running tallies for the display logic.

Parameters:
- NUM_CHIPS, 4: number of tester blocks attached.
- SEL_W, 2: width of the chip select.
- TIMEOUT_CYCLES, 1024: maximum number of WAIT cycles before the test is declared timed out.
- TO_W, 11: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  synchronized user start level; only its rising edge is acted on.
- ChipSel  in  SEL_W  index of the tester to run.
- Run_vec  out  NUM_CHIPS  per-tester Run strobe.
- Done_vec  in  NUM_CHIPS  per-tester Done.
- RSLT_vec  in  NUM_CHIPS  per-tester RSLT.
- DISP_RSLT  out  1  acknowledge, broadcast to all testers.
- Busy  out  1  high from LAUNCH through ACK.
- Result_valid  out  1  high in SHOW.
- Pass  out  1  captured pass.
- Fail  out  1  captured fail (includes timeout).
- Timeout  out  1  last test timed out.
- Shown_chip  out  SEL_W  index latched at launch.
- Pass_count  out  8  saturating pass tally.
- Fail_count  out  8  saturating fail tally.

Behaviour:
- Reset values (synchronous): state IDLE; all outputs 0; counts 0; start_prev 0; timeout counter 0. Reset in any state, including mid-WAIT, aborts immediately. Run_vec and DISP_RSLT are 0 from the next edge. Testers share Reset.
- start_rise = Start & ~start_prev, where start_prev is registered every cycle.
- States: IDLE, LAUNCH, WAIT, ACK, SHOW.
- IDLE:
  - On start_rise with ChipSel < NUM_CHIPS: latch sel into Shown_chip, go to LAUNCH.
  - On start_rise with ChipSel >= NUM_CHIPS: ignore, stay in IDLE.
- SHOW: same start_rise rule as IDLE. Starting a new test clears Pass, Fail, Timeout and Result_valid on entry to LAUNCH.
- LAUNCH:
  - Run_vec[sel] = 1 for exactly this one cycle; all other bits 0.
  - Clear the timeout counter and done_d.
  - Go to WAIT.
- WAIT:
  - done_d <= Done_vec[sel] each cycle.
  - The tester raises Done combinationally on its last test vector, before its registered RSLT is final. Capture therefore happens only on the second consecutive Done-high cycle (Done_vec[sel] & done_d).
  - At capture: Pass <= RSLT_vec[sel], Fail <= ~RSLT_vec[sel], then go to ACK.
  - Otherwise increment the counter. If the counter == TIMEOUT_CYCLES-1 with no capture: Timeout <= 1, Fail <= 1, Pass <= 0, go to ACK.
  - If capture and timeout coincide in the same cycle, capture wins.
- ACK:
  - DISP_RSLT = 1 for exactly one cycle; the tester returns to Halted.
  - Update the counts: Pass_count += Pass, Fail_count += Fail, each saturating at 255 with no wrap.
  - Result_valid <= 1; go to SHOW.
- Busy = 1 in LAUNCH, WAIT and ACK. start_rise is ignored while Busy.
- Inputs Done_vec/RSLT_vec of non-selected chips are ignored throughout.
- ChipSel changes after launch do not affect Shown_chip or the run in progress.
- Nominal latency with the 7410 tester (Set 1 cycle, Test 8 cycles): start_rise edge → Run 1 cycle later → capture about 11 cycles after Run → DISP_RSLT the following cycle.

Test Plan:
1. Good-chip model on index 1, ChipSel=1, Start 0→1 → Run_vec=4'b0010 for 1 cycle; Busy high; capture 2nd Done cycle with RSLT=1; DISP_RSLT 1 cycle; Pass=1, Fail=0, Result_valid=1, Pass_count=1, Shown_chip=1.
2. Faulty model (one NAND output stuck 1), ChipSel=0 → Pass=0, Fail=1, Fail_count=1. Verify RSLT sampled only on the second Done cycle by a model whose RSLT is 1 on the first Done cycle and 0 on the second → Fail=1.
3. Tester never asserts Done, TIMEOUT_CYCLES=16 → Timeout=Fail=1 exactly 16 cycles after entering WAIT; DISP_RSLT pulses once.
4. Start toggled repeatedly while Busy, and ChipSel changed mid-WAIT → no extra Run pulse; Shown_chip unchanged; single result.
5. Reset asserted mid-WAIT → next cycle: IDLE, all outputs 0, counts 0. A subsequent Start rise runs normally.
6. ChipSel=3 with NUM_CHIPS=3 → Start ignored, Run_vec=0. After 256 passing runs → Pass_count=255 (saturated).
